// File: rtl/xor_stream_decrypt_if.sv
// Valid/ready ciphertext-in and plaintext-out streams of the XOR stream decryptor.
// The decryptor uses the slave view. The source/sink that drives it uses the master view.
interface xor_stream_decrypt_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/xor_stream_decrypt.sv
// Word-serial XOR stream decryptor.
// The keystream comes from a 32-bit Galois LFSR (x^32 + x^22 + x^2 + x + 1).
// The datapath has one registered output stage and supports full throughput.
module xor_stream_decrypt #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      seed,
   input  logic [LEN_W-1:0] length,
   xor_stream_decrypt_if.slave stream,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   state_t           state_next;
   logic [31:0]      lfsr;
   logic [LEN_W-1:0] count;
   logic             out_valid;
   logic [31:0]      out_data;
   logic             in_ready;
   logic             accept;
   logic             out_fire;
   logic             drain_exit;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   // Handshake qualifiers. The output register may refill in the same cycle it is drained.
   always_comb begin
      in_ready   = (state == RUN) && (!out_valid || stream.out_ready);
      accept     = stream.in_valid && in_ready;
      out_fire   = out_valid && stream.out_ready;
      drain_exit = (state == DRAIN) && (!out_valid || stream.out_ready);
   end

   assign stream.in_ready  = in_ready;
   assign stream.out_valid = out_valid;
   assign stream.out_data  = out_data;
   assign busy             = (state != IDLE);

   // Next-state logic: IDLE -> RUN/DRAIN on start, RUN -> DRAIN on last word, DRAIN -> IDLE once the output empties.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (length != '0) ? RUN : DRAIN;
            end
         end
         RUN: begin
            if (accept && (count == LEN_W'(1))) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Keystream generator and word counter.
   // Both are loaded on start and advance once per accepted word.
   // A zero seed would lock the LFSR at zero, so it is replaced by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr  <= 32'h00000001;
         count <= '0;
      end else if ((state == IDLE) && start) begin
         lfsr  <= (seed == 32'h0) ? 32'h00000001 : seed;
         count <= length;
      end else if (accept) begin
         lfsr  <= lfsr_step(lfsr);
         count <= count - LEN_W'(1);
      end
   end

   // Output register: it reloads on accept, clears when drained with no refill, and holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 32'h0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= stream.in_data ^ lfsr;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

   // Completion pulse: high for the one cycle after the block leaves DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
      end else begin
         done <= drain_exit;
      end
   end

endmodule

// File: doc/xor_stream_decrypt.md
# xor_stream_decrypt

Word-serial stream decryptor for the ALU datapath. It recovers 32-bit plaintext words from a ciphertext stream that was produced by XOR-ing plaintext with a keystream. The keystream comes from a 32-bit Galois LFSR, and the encrypting end runs the identical generator from the same seed. The block sits between a valid/ready ciphertext source and a valid/ready plaintext sink, with one registered pipeline stage.

## Interface
- LEN_W, default 8: width of the word-count input and the internal counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a message. Sampled only in IDLE.
- seed  input  32  LFSR seed, captured when start is accepted.
- length  input  LEN_W  number of words in the message, captured when start is accepted.
- in_valid  input  1  ciphertext word available.
- in_ready  output  1  block accepts a ciphertext word this cycle.
- in_data  input  32  ciphertext word.
- out_valid  output  1  plaintext word available.
- out_ready  input  1  sink accepts the plaintext word.
- out_data  output  32  plaintext word.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a message completes.

## Operation
- **LFSR step:** `next = s[0] ? (s >> 1) ^ 32'h80200003 : s >> 1`.
  - Polynomial: x^32 + x^22 + x^2 + x + 1.
- **Keystream:** word i uses the LFSR state *before* step i. The generator steps exactly once per accepted input word.
- **Seed:** a seed of 0 is replaced by 32'h00000001 (avoids lockup).
- **Datapath:** `out_data <= in_data ^ lfsr` on each accept. The XOR is full 32-bit and bitwise; there is no carry.
- **States:** IDLE, RUN, DRAIN.
  - **IDLE:** in_ready = 0.
    - On start = 1: load the LFSR from seed and load the counter from length.
    - Next state is RUN if length ≠ 0, otherwise DRAIN.
  - **RUN:** `in_ready = !out_valid || out_ready` (combinational).
    - An accept is `in_valid && in_ready`.
    - On an accept: load out_data, set out_valid = 1, step the LFSR, decrement the counter.
    - When the accept makes the counter reach 0, go to DRAIN.
  - **DRAIN:** in_ready = 0.
    - When out_valid = 0, or `out_valid && out_ready`: clear out_valid, pulse done, go to IDLE.
- **Output handshake:** when `out_valid && out_ready` with no simultaneous accept, out_valid clears.
- **Simultaneous accept and output handshake:** the register reloads and out_valid stays 1. This gives full throughput of one word per cycle.
- **start outside IDLE** is ignored. seed and length are not re-sampled.
- **Backpressure:** out_data and out_valid hold stable while `out_valid && !out_ready`.
- **Reset mid-message:** asynchronous. Everything returns to reset values immediately, and any partial message is discarded.

## Timing
- **Reset values:**
  - Outputs: in_ready 0, out_valid 0, out_data 32'h0, busy 0, done 0.
  - Internal: lfsr 32'h00000001, counter 0, state IDLE.
- **Start:** start sampled at edge k puts the block in RUN (or DRAIN) after edge k. busy is 1 from edge k onward.
- **Latency:** an accept at edge n gives out_valid = 1 after edge n, i.e. one cycle.
- **Completion:**
  - done = 1 and busy = 0 in the cycle after the edge on which the last output handshake occurs.
  - done is low on all other cycles.
- **Empty message (length = 0):** done is high in the cycle after edge k+1. out_valid never asserts.
- **Back-to-back messages:** start can be accepted in the same cycle that done is high (state is IDLE).

## Test plan
- **Basic keystream:** seed 32'h1, length 3, in_data 0, 0, 0, out_ready held 1 → out_data 32'h00000001, 32'h80200003, 32'hC0300002 on three consecutive cycles; done pulses once afterwards.
- **Round trip:** encryptor model with seed 32'hA5A5A5A5, 16 random words, random in_valid/out_ready gaps → output equals the original plaintext, in order, with no drops or duplicates; exactly 16 output handshakes.
- **Backpressure:** out_ready = 0 for 5 cycles after the first output → in_ready = 0 while out_valid is held, out_data stays stable; on release, the stream resumes at one word per cycle.
- **Empty message and zero seed:**
  - length 0 → done 2 edges after start, no out_valid.
  - seed 0, length 1, in_data 32'hDEADBEEF → out_data 32'hDEADBEEE.
- **start while busy:** pulse start during RUN with a different seed and length → ignored; the original message completes unchanged.
- **Reset mid-stream:** assert rst_n = 0 after 2 of 5 words, between clock edges → outputs go to reset values immediately; a new start with seed 1, length 1 then behaves as in the basic keystream test.
